// File: rtl/rv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32i_pkg                                                    |
// | Description : Shared fetch types and constants: PC width, NOP encoding and |
// |               the fetch-buffer entry layout.                               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package rv32i_pkg;

    localparam int          c_PC_W = 32;
    localparam logic [31:0] c_NOP  = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [31:0]       instr;
        logic [c_PC_W-1:0] pc;
        logic              misalign;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_buf                                                    |
// | Description : Two-entry fetch FIFO with flush; head and valid registered.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fetch_buf
    import rv32i_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    output logic [1:0]   o_count,
    output logic         o_valid,
    output fetch_entry_t o_head
);

    fetch_entry_t r_ent [2];
    logic [1:0]   r_count;
    logic         r_valid;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    assign w_pop     = i_pop && r_valid;
    assign w_cnt_nxt = r_count + {1'b0, i_push} - {1'b0, w_pop};

    // Push into a full buffer cannot occur: the issue rule reserves a slot
    // for every outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent[0] <= '0;
            r_ent[1] <= '0;
            r_count  <= 2'd0;
            r_valid  <= 1'b0;
        end else if (i_flush) begin
            r_count  <= 2'd0;
            r_valid  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ent[0] <= r_ent[1];
            end
            if (i_push) begin
                if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
                    r_ent[0] <= i_push_data;
                end else begin
                    r_ent[1] <= i_push_data;
                end
            end
            r_count <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != 2'd0);
        end
    end

    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_head  = r_ent[0];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch                                                  |
// | Description : Sequential-PC instruction fetch with redirect and 2-entry    |
// |               decoupling buffer. Optional IFETCH_MISALIGN_TRAP_EN turns a  |
// |               misaligned redirect into a flagged NOP and halts fetch.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [c_PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                MEM_DEPTH = 1024
)(
    input  logic              clk,
    input  logic              rst,
    output logic [c_PC_W-1:0] imem_pc,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [c_PC_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [c_PC_W-1:0] if_pc,
    output logic              if_misalign
);

    if (MEM_DEPTH < 1) begin : g_depth_chk
        $error("instr_fetch: MEM_DEPTH must be positive");
    end

    logic [c_PC_W-1:0] r_pc;
    logic [c_PC_W-1:0] r_req_pc;
    logic              r_inflight;
    logic              r_halt;

    logic [1:0]        w_count;
    logic              w_valid;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic [c_PC_W-1:0] w_target;
    logic              w_mis_redirect;
    logic              w_mis_push;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic r_mis_pend;
    logic r_mis_inflight;

    assign w_target       = redirect_pc;
    assign w_mis_redirect = (redirect_pc[1:0] != 2'b00);
    assign w_mis_push     = r_mis_inflight;

    // Two-stage delay so the trap entry lands with the same latency as a fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis_pend     <= 1'b0;
            r_mis_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_mis_pend     <= w_mis_redirect;
            r_mis_inflight <= 1'b0;
        end else begin
            r_mis_pend     <= 1'b0;
            r_mis_inflight <= r_mis_pend;
        end
    end
`else
    assign w_target       = redirect_pc & ~32'h0000_0003;
    assign w_mis_redirect = 1'b0;
    assign w_mis_push     = 1'b0;
`endif

    assign w_pop   = w_valid && if_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = !redirect_valid && !r_halt && (w_occ <= 3'd1);
    assign w_push  = (r_inflight || w_mis_push) && !redirect_valid;

    always_comb begin
        w_push_data.instr    = imem_instr;
        w_push_data.pc       = r_req_pc;
        w_push_data.misalign = 1'b0;
        if (w_mis_push) begin
            w_push_data.instr    = c_NOP;
            w_push_data.pc       = r_pc;
            w_push_data.misalign = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_halt     <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
            r_halt     <= w_mis_redirect;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
        end
    end

    fetch_buf u_fetch_buf (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_head      (w_head)
    );

    assign imem_pc     = r_pc;
    assign if_valid    = w_valid;
    assign if_instr    = w_head.instr;
    assign if_pc       = w_head.pc;
    assign if_misalign = w_head.misalign;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch                                               |
// | Description : Directed self-checking bench for instr_fetch; memory returns |
// |               word index (addr >> 2) one cycle after the address.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_misalign;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_DEPTH (1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_misalign    (if_misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_instr <= {2'b00, imem_pc[31:2]};

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] imem;
        logic        z;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    vec_t tv [14];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins, input logic mis);
        chk({nm, "_valid"}, {31'b0, if_valid}, {31'b0, v});
        if (v) begin
            chk({nm, "_pc"}, if_pc, pc);
            chk({nm, "_instr"}, if_instr, ins);
            chk({nm, "_mis"}, {31'b0, if_misalign}, {31'b0, mis});
        end
    endtask

    task automatic redir(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        //            rst   rdy   imem          z     v     pc            ins
        tv[0]  = '{1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 32'd0};
        tv[1]  = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 32'd0};
        tv[2]  = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 32'h00, 32'd0};
        tv[3]  = '{1'b0, 1'b1, 32'h08, 1'b0, 1'b1, 32'h00, 32'd0};
        tv[4]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 32'h04, 32'd1};
        tv[5]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h08, 32'd2};
        tv[6]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h08, 32'd2};
        tv[7]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h08, 32'd2};
        tv[8]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h08, 32'd2};
        tv[9]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h08, 32'd2};
        tv[10] = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h08, 32'd2};
        tv[11] = '{1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 32'h0C, 32'd3};
        tv[12] = '{1'b0, 1'b1, 32'h18, 1'b0, 1'b1, 32'h10, 32'd4};
        tv[13] = '{1'b0, 1'b1, 32'h1C, 1'b0, 1'b1, 32'h14, 32'd5};

        rst            = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        cyc();
        cyc();

        // Reset release, streaming, then a 5-cycle stall on pc 0x8.
        for (int i = 0; i < 14; i++) begin
            rst      = tv[i].rst;
            if_ready = tv[i].rdy;
            chk($sformatf("A%0d_imem_pc", i), imem_pc, tv[i].imem);
            if (tv[i].z) begin
                chk($sformatf("A%0d_rst_pc", i), if_pc, 32'h0);
                chk($sformatf("A%0d_rst_instr", i), if_instr, 32'h0);
                chk($sformatf("A%0d_rst_mis", i), {31'b0, if_misalign}, 32'h0);
            end
            chk_out($sformatf("A%0d", i), tv[i].v, tv[i].pc, tv[i].ins, 1'b0);
            cyc();
        end

        // Redirect with the buffer committed full (one entry + one in flight).
        if_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        chk_out("B_pre", 1'b1, 32'h0, 32'h0, 1'b0);
        redir(32'h100);
        chk("B_imem_pc", imem_pc, 32'h100);
        chk_out("B_n1", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("B_n2", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("B_n3", 1'b1, 32'h100, 32'h40, 1'b0);
        if_ready = 1'b1;
        cyc();
        chk_out("B_n4", 1'b1, 32'h104, 32'h41, 1'b0);

        // Redirect coincides with pop and push.
        redir(32'h300);
        chk_out("C_n1", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("C_n2", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("C_n3", 1'b1, 32'h300, 32'hC0, 1'b0);

        // Back-to-back redirects: the last wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        cyc();
        redir(32'h500);
        chk("R_imem_pc", imem_pc, 32'h500);
        chk_out("R_n1", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("R_n2", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("R_n3", 1'b1, 32'h500, 32'h140, 1'b0);
        cyc();
        chk_out("R_n4", 1'b1, 32'h504, 32'h141, 1'b0);

        // PC wrap at the top of the address space.
        redir(32'hFFFF_FFFC);
        cyc();
        cyc();
        chk_out("W_top", 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b0);
        cyc();
        chk_out("W_wrap", 1'b1, 32'h0, 32'h0, 1'b0);

        // Misaligned redirect target.
        redir(32'h102);
        cyc();
        cyc();
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk_out("M_trap", 1'b1, 32'h102, 32'h13, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_out($sformatf("M_halt%0d", k), 1'b0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("M_halt%0d_imem_pc", k), imem_pc, 32'h102);
        end
        redir(32'h200);
        cyc();
        cyc();
        chk_out("M_resume", 1'b1, 32'h200, 32'h80, 1'b0);
`else
        chk_out("M_forced", 1'b1, 32'h100, 32'h40, 1'b0);
        cyc();
        chk_out("M_next", 1'b1, 32'h104, 32'h41, 1'b0);
`endif

        // Reset asserted mid-stream discards everything.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("S_imem_pc", imem_pc, 32'h0);
        chk("S_rst_pc", if_pc, 32'h0);
        chk_out("S_n1", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("S_n2", 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("S_n3", 1'b1, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_out("S_n4", 1'b1, 32'h4, 32'h1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
